// File: rtl/mvau_ctrl_pkg.sv
// Shared types for the MVAU PE fold controller: FSM states, pipeline flag token and width helpers.
package mvau_ctrl_pkg;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } token_t;

  localparam int PERF_W = 32;

  // Counter width that stays legal (>=1 bit) when the range collapses to a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvu_pe_fold_ctrl_if.sv
// Activation-in and result-out valid/ready handshakes of the PE fold controller.
interface mvu_pe_fold_ctrl_if;
  logic in_v;
  logic in_rdy;
  logic out_v;
  logic out_rdy;

  modport master (output in_v, output out_rdy, input in_rdy, input out_v);
  modport slave  (input in_v, input out_rdy, output in_rdy, output out_v);
endinterface

// File: rtl/mvu_pe_ctrl_pipe.sv
// Flag-token delay line matching the SIMD lane + adder tree depth; PIPE_LAT stages.
// Shifts only while en_i is high so tokens stay aligned with a frozen datapath.
module mvu_pe_ctrl_pipe
  import mvau_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  token_t tok_i,
  output token_t tap_o
);

  token_t line_q [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) line_q[i] <= '0;
    end else if (en_i) begin
      line_q[0] <= tok_i;
      for (int i = 1; i < PIPE_LAT; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign tap_o = line_q[PIPE_LAT-1];

endmodule

// File: rtl/mvu_pe_fold_ctrl.sv
// Fold sequencer for one binary-SIMD PE: buffers activations on the first neuron fold, replays them after.
// One issue per cycle; out_v && !out_rdy freezes the whole datapath. MVAU_CTRL_PERF_EN adds stall/frame counters.
module mvu_pe_fold_ctrl
  import mvau_ctrl_pkg::*;
#(
  parameter int SF       = 4,
  parameter int NF       = 2,
  parameter int PIPE_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  mvu_pe_fold_ctrl_if.slave         hs,
  output logic                      ibuf_we,
  output logic [cnt_w(SF)-1:0]      ibuf_addr,
  output logic                      ibuf_sel,
  output logic [cnt_w(SF*NF)-1:0]   wmem_addr,
  output logic                      pipe_en,
  output logic                      acc_en,
  output logic                      acc_clr,
  output logic [PERF_W-1:0]         stall_cnt,
  output logic [PERF_W-1:0]         frame_cnt
);

  localparam int SW = cnt_w(SF);
  localparam int NW = cnt_w(NF);
  localparam int WW = cnt_w(SF*NF);

  state_e          state_q, state_d;
  logic [SW-1:0]   sf_q;
  logic [NW-1:0]   nf_q;
  logic [WW-1:0]   waddr_q;
  logic            issue, sf_last, nf_last;
  logic            out_v_q, out_v_d;
  token_t          tok_in, tap;

  assign pipe_en = !(out_v_q && !hs.out_rdy);
  assign sf_last = (sf_q == SW'(SF-1));
  assign nf_last = (nf_q == NW'(NF-1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    hs.in_rdy = 1'b0;
    ibuf_sel  = 1'b0;
    case (state_q)
      FILL: begin
        hs.in_rdy = pipe_en;
        issue     = hs.in_v && pipe_en;
        if (issue && sf_last && (NF > 1)) state_d = REPLAY;
      end
      REPLAY: begin
        ibuf_sel = 1'b1;
        issue    = pipe_en;
        if (issue && sf_last && nf_last) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign ibuf_we   = issue && (state_q == FILL);
  assign ibuf_addr = sf_q;
  assign wmem_addr = waddr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sf_q    <= '0;
      nf_q    <= '0;
      waddr_q <= '0;
    end else if (issue) begin
      sf_q    <= sf_last ? '0 : sf_q + 1'b1;
      if (sf_last) nf_q <= nf_last ? '0 : nf_q + 1'b1;
      waddr_q <= (waddr_q == WW'(SF*NF-1)) ? '0 : waddr_q + 1'b1;
    end
  end

  always_comb begin
    tok_in       = '0;
    tok_in.valid = issue;
    tok_in.first = issue && (sf_q == '0);
    tok_in.last  = issue && sf_last;
  end

  mvu_pe_ctrl_pipe #(.PIPE_LAT(PIPE_LAT)) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .en_i  (pipe_en),
    .tok_i (tok_in),
    .tap_o (tap)
  );

  assign acc_en  = tap.valid && pipe_en;
  assign acc_clr = acc_en && tap.first;

  // Set wins over clear so a new result can follow an accepted one with no bubble.
  always_comb begin
    out_v_d = out_v_q;
    if (out_v_q && hs.out_rdy) out_v_d = 1'b0;
    if (acc_en && tap.last)    out_v_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) out_v_q <= 1'b0;
    else     out_v_q <= out_v_d;
  end

  assign hs.out_v = out_v_q;

`ifdef MVAU_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_q, frame_q;
  logic [NW-1:0]     onf_q;

  // onf_q tracks which neuron fold the next accepted output belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      frame_q <= '0;
      onf_q   <= '0;
    end else begin
      if (out_v_q && !hs.out_rdy && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (out_v_q && hs.out_rdy) begin
        onf_q <= (onf_q == NW'(NF-1)) ? '0 : onf_q + 1'b1;
        if ((onf_q == NW'(NF-1)) && (frame_q != '1)) frame_q <= frame_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign frame_cnt = frame_q;
`else
  assign stall_cnt = '0;
  assign frame_cnt = '0;
`endif

endmodule
